// File: rtl/zoran_nios_dbg_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG host driver.
// Optional feature macro: DBG_DRV_RTI_EN (adds the run-test-idle state).
package zoran_nios_dbg_pkg;

  localparam int DR_WIDTH_DEF = 38;

  localparam logic [1:0] IR_OCIMEM_A = 2'd0;
  localparam logic [1:0] IR_OCIMEM_B = 2'd1;
  localparam logic [1:0] IR_BREAK    = 2'd2;
  localparam logic [1:0] IR_TRACE    = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    DONE
  } drv_state_t;

endpackage

// File: rtl/zoran_nios_dbg_tck_gen.sv
// TCK generator: TCK_DIV clks low then TCK_DIV clks high while enabled.
// tck_rise/tck_fall flag the clk edge at which tck is about to change.
module zoran_nios_dbg_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int CW = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(TCK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;

  always_comb begin
    cnt_d = '0;
    if (en && cnt_q != LAST) cnt_d = cnt_q + CW'(1);
    tck_d = en && (cnt_d >= HALF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck      = tck_q;
  assign tck_rise = en && (cnt_q == HALF - CW'(1));
  assign tck_fall = en && (cnt_q == LAST);

endmodule

// File: rtl/zoran_nios_dbg_jtag_driver.sv
// Host-side virtual-JTAG driver: runs UIR/CDR/SDR/UDR for one command.
// Define DBG_DRV_RTI_EN to insert run-test-idle periods after UDR.
module zoran_nios_dbg_jtag_driver
  import zoran_nios_dbg_pkg::*;
#(
  parameter int DR_WIDTH   = DR_WIDTH_DEF,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CMAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  drv_state_t          state_q, state_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tdi_q, tdi_d;
  logic                tck_en, tck_rise, tck_fall;

  assign tck_en = (state_q != IDLE) && (state_q != DONE);

  zoran_nios_dbg_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk      (clk),
    .reset    (reset),
    .en       (tck_en),
    .tck      (vji_tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    rsp_dr_d = rsp_dr_q;
    rsp_ir_d = rsp_ir_q;
    ir_in_d  = ir_in_q;
    cnt_d    = cnt_q;
    tdi_d    = tdi_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = UIR;
        shift_d = cmd_dr;
        ir_in_d = cmd_ir;
        tdi_d   = 1'b0;
      end
      UIR: if (tck_fall) state_d = CDR;
      CDR: if (tck_fall) begin
        state_d = SDR;
        cnt_d   = '0;
        tdi_d   = shift_q[0];
      end
      SDR: begin
        if (tck_rise) shift_d = {vji_tdo, shift_q[DR_WIDTH-1:1]};
        if (tck_fall) begin
          if (cnt_q == CW'(DR_WIDTH - 1)) begin
            state_d = UDR;
            tdi_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            tdi_d = shift_q[0];
          end
        end
      end
      UDR: begin
        if (tck_rise) rsp_ir_d = vji_ir_out;
        if (tck_fall) begin
          rsp_dr_d = shift_q;
`ifdef DBG_DRV_RTI_EN
          state_d = RTI;
          cnt_d   = '0;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef DBG_DRV_RTI_EN
      RTI: if (tck_fall) begin
        if (cnt_q == CW'(RTI_CYCLES - 1)) state_d = DONE;
        else cnt_d = cnt_q + CW'(1);
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      rsp_dr_q <= '0;
      rsp_ir_q <= '0;
      ir_in_q  <= '0;
      cnt_q    <= '0;
      tdi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      rsp_dr_q <= rsp_dr_d;
      rsp_ir_q <= rsp_ir_d;
      ir_in_q  <= ir_in_d;
      cnt_q    <= cnt_d;
      tdi_q    <= tdi_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_dr    = rsp_dr_q;
  assign rsp_ir    = rsp_ir_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_in_q;
  assign vji_uir   = (state_q == UIR);
  assign vji_cdr   = (state_q == CDR);
  assign vji_sdr   = (state_q == SDR);
  assign vji_udr   = (state_q == UDR);
`ifdef DBG_DRV_RTI_EN
  assign vji_rti   = (state_q == RTI);
`else
  assign vji_rti   = 1'b0;
`endif

endmodule
